// File: rtl/fb_pkg.sv
// Shared constants and pixel-byte layout for the framebuffer scan-out path.
// Pixel byte: type [7:6], colour [5:4], gray [5:2].
package fb_pkg;
  localparam int FB_W    = 320;
  localparam int FB_H    = 240;
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int ADDR_W  = 18;

  localparam int PX_TYPE_MSB = 7;
  localparam int PX_TYPE_LSB = 6;
  localparam int PX_COL_MSB  = 5;
  localparam int PX_COL_LSB  = 4;
  localparam int PX_GRAY_MSB = 5;
  localparam int PX_GRAY_LSB = 2;

  typedef enum logic [1:0] {
    PX_GRAY  = 2'b00,
    PX_TEXT  = 2'b01,
    PX_SPR   = 2'b10,
    PX_DRAWN = 2'b11
  } px_type_e;

  localparam logic [1:0] COL_RED = 2'b11;

  function automatic logic [7:0] px_drawn(input logic [1:0] colour);
    logic [7:0] px;
    px = '0;
    px[PX_TYPE_MSB:PX_TYPE_LSB] = PX_DRAWN;
    px[PX_COL_MSB:PX_COL_LSB]   = colour;
    return px;
  endfunction
endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register with asynchronous clear, used to align
// timing and qualifier bits with the BRAM read pipeline.
module sync_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);
  import fb_pkg::*;

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d_in;
    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign q_out = stage_q[DEPTH-1];
endmodule

// File: rtl/fb_scan_reader.sv
// Double-buffered framebuffer scan-out: raster counters -> BRAM address -> pixel byte.
// Optional cursor crosshair overlay under macro FB_CURSOR_EN.
module fb_scan_reader #(
  parameter int FB_W       = fb_pkg::FB_W,
  parameter int FB_H       = fb_pkg::FB_H,
  parameter int SCALE_LOG2 = 1,
  parameter int RD_LAT     = 2,
  parameter int H_ACTIVE   = 640,
  parameter int V_TOTAL    = 525
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [10:0]               hcount_in,
  input  logic [9:0]                vcount_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      blank_in,
  input  logic                      swap_req_in,
  output logic                      swap_ack_out,
  output logic                      front_sel_out,
  output logic [fb_pkg::ADDR_W-1:0] addr_out,
  input  logic [7:0]                rd_data_in,
  output logic [7:0]                pixel_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      blank_out
`ifdef FB_CURSOR_EN
  ,
  input  logic [10:0]               cursor_x_in,
  input  logic [9:0]                cursor_y_in
`endif
);
  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] PAGE     = ADDR_W'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);
  localparam logic [10:0]       H_WIN    = 11'(FB_W << SCALE_LOG2);
  localparam logic [9:0]        V_WIN    = 10'(FB_H << SCALE_LOG2);
  localparam logic [10:0]       H_END    = 11'(H_ACTIVE);
  localparam logic [9:0]        V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]        SUB_MASK = 10'((1 << SCALE_LOG2) - 1);

  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d, page_sel;
  logic [10:0]       col;
  logic [9:0]        vnext;
  logic              in_win, win_dly;
  logic              vs_prev_q, vs_fall;
  logic              pending_q, pending_d;
  logic              front_q, front_d;
  logic              ack_q, ack_d;
  logic [7:0]        pixel_q, pixel_d;

  // Row base advances once per source row, at the end of each active line,
  // so the address needs only an add instead of a v*FB_W multiply.
  always_comb begin
    col      = hcount_in >> SCALE_LOG2;
    vnext    = vcount_in + 10'd1;
    in_win   = (hcount_in < H_WIN) && (vcount_in < V_WIN) && !blank_in;
    page_sel = front_q ? PAGE : '0;
    addr_d   = in_win ? (row_base_q + ADDR_W'(col) + page_sel) : page_sel;

    row_base_d = row_base_q;
    if (hcount_in == H_END) begin
      if (vcount_in == V_LAST)             row_base_d = '0;
      else if ((vnext & SUB_MASK) == '0)   row_base_d = row_base_q + ROW_STEP;
    end
  end

  // A request arriving on the flip cycle is absorbed by that flip.
  always_comb begin
    vs_fall   = vs_prev_q && !vsync_in;
    pending_d = pending_q;
    front_d   = front_q;
    ack_d     = 1'b0;
    if (vs_fall && pending_q) begin
      front_d   = !front_q;
      ack_d     = 1'b1;
      pending_d = 1'b0;
    end else if (swap_req_in) begin
      pending_d = 1'b1;
    end
  end

  sync_delay #(.DEPTH(RD_LAT + 1), .WIDTH(1)) u_win_dly (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   (in_win),
    .q_out  (win_dly)
  );

  sync_delay #(.DEPTH(RD_LAT + 2), .WIDTH(3)) u_tim_dly (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   ({hsync_in, vsync_in, blank_in}),
    .q_out  ({hsync_out, vsync_out, blank_out})
  );

`ifdef FB_CURSOR_EN
  logic [10:0] hcount_dly;
  logic [9:0]  vcount_dly;

  sync_delay #(.DEPTH(RD_LAT + 1), .WIDTH(21)) u_pos_dly (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   ({hcount_in, vcount_in}),
    .q_out  ({hcount_dly, vcount_dly})
  );

  always_comb begin
    pixel_d = win_dly ? rd_data_in : 8'h00;
    if (win_dly && ((hcount_dly == cursor_x_in) || (vcount_dly == cursor_y_in)))
      pixel_d = px_drawn(COL_RED);
  end
`else
  always_comb begin
    pixel_d = win_dly ? rd_data_in : 8'h00;
  end
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      row_base_q <= '0;
      addr_q     <= '0;
      pixel_q    <= '0;
      vs_prev_q  <= 1'b0;
      pending_q  <= 1'b0;
      front_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      pixel_q    <= pixel_d;
      vs_prev_q  <= vsync_in;
      pending_q  <= pending_d;
      front_q    <= front_d;
      ack_q      <= ack_d;
    end
  end

  assign addr_out      = addr_q;
  assign pixel_out     = pixel_q;
  assign front_sel_out = front_q;
  assign swap_ack_out  = ack_q;
endmodule

// File: tb/tb_fb_scan_reader.sv
// Directed bench for fb_scan_reader: sparse raster scan over six frames with
// a 2-cycle BRAM model holding RAM[a] = a[7:0].
module tb_fb_scan_reader;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        blank_in = 1'b0;
  logic        swap_req_in = 1'b0;
  logic        swap_ack_out, front_sel_out;
  logic [17:0] addr_out;
  logic [7:0]  rd_data_in;
  logic [7:0]  pixel_out;
  logic        hsync_out, vsync_out, blank_out;

  always #5 clk_in = ~clk_in;

  fb_scan_reader dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .blank_in      (blank_in),
    .swap_req_in   (swap_req_in),
    .swap_ack_out  (swap_ack_out),
    .front_sel_out (front_sel_out),
    .addr_out      (addr_out),
    .rd_data_in    (rd_data_in),
    .pixel_out     (pixel_out),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .blank_out     (blank_out)
  );

  // BRAM with two cycles of read latency
  logic [7:0] ram_s1 = '0;
  logic [7:0] ram_s2 = '0;
  always_ff @(posedge clk_in) begin
    ram_s1 <= addr_out[7:0];
    ram_s2 <= ram_s1;
  end
  assign rd_data_in = ram_s2;

  typedef struct {
    bit          valid;
    logic [17:0] addr;
    logic [7:0]  pix;
    logic        hs, vs, bl, front;
    int          h, v;
  } ent_t;

  ent_t hist[4];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cur_frame = 0;
  int   frame_acks = 0;
  int   max_addr = 0;
  bit   chk_en = 1'b1;
  bit   prev_ok = 1'b0;
  bit   model_front = 1'b0;
  bit   model_ack = 1'b0;
  bit   pending = 1'b0;
  bit   prev_vs = 1'b1;

  localparam int HS [12] = '{0, 1, 5, 100, 319, 320, 321, 638, 639, 640, 641, 700};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int h, input int v, input bit req);
    ent_t e;
    bit   inw, fall;
    @(negedge clk_in);
    if (chk_en && hist[3].valid) begin
      check("pixel", 32'(pixel_out), 32'(hist[3].pix));
      check("hsync_dly", 32'(hsync_out), 32'(hist[3].hs));
      check("vsync_dly", 32'(vsync_out), 32'(hist[3].vs));
      check("blank_dly", 32'(blank_out), 32'(hist[3].bl));
      if (cur_frame == 0 && hist[3].h == 5 && hist[3].v == 3)
        check("req022_pix", 32'(pixel_out), 66);
    end
    if (chk_en && hist[0].valid) begin
      check("addr", 32'(addr_out), 32'(hist[0].addr));
      if (int'(addr_out) > max_addr) max_addr = int'(addr_out);
      if (cur_frame == 0 && hist[0].h == 5 && hist[0].v == 3)
        check("req022_addr", 32'(addr_out), 322);
      if (hist[0].front && hist[0].h == 0 && hist[0].v == 0)
        check("req024_addr", 32'(addr_out), 76800);
    end
    if (chk_en && prev_ok) begin
      check("front", 32'(front_sel_out), 32'(model_front));
      check("ack", 32'(swap_ack_out), 32'(model_ack));
    end
    if (swap_ack_out) frame_acks++;

    e.valid = 1'b1;
    e.h     = h;
    e.v     = v;
    e.hs    = !(h >= 656 && h < 752);
    e.vs    = !(v >= 490 && v < 492);
    e.bl    = (h >= 640) || (v >= 480);
    e.front = model_front;
    inw     = !e.bl;
    e.addr  = 18'((model_front ? 76800 : 0) + (inw ? (v / 2) * 320 + h / 2 : 0));
    e.pix   = inw ? e.addr[7:0] : 8'h00;

    fall      = prev_vs && !e.vs;
    model_ack = 1'b0;
    if (fall && pending) begin
      model_front = !model_front;
      model_ack   = 1'b1;
      pending     = 1'b0;
    end else if (req) begin
      pending = 1'b1;
    end
    prev_vs = e.vs;

    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = e;
    prev_ok = 1'b1;

    hcount_in   = 11'(h);
    vcount_in   = 10'(v);
    hsync_in    = e.hs;
    vsync_in    = e.vs;
    blank_in    = e.bl;
    swap_req_in = req;
  endtask

  task automatic check_all_zero(input string sfx);
    check({"rst_addr", sfx}, 32'(addr_out), 0);
    check({"rst_pixel", sfx}, 32'(pixel_out), 0);
    check({"rst_front", sfx}, 32'(front_sel_out), 0);
    check({"rst_ack", sfx}, 32'(swap_ack_out), 0);
    check({"rst_hsync", sfx}, 32'(hsync_out), 0);
    check({"rst_vsync", sfx}, 32'(vsync_out), 0);
    check({"rst_blank", sfx}, 32'(blank_out), 0);
  endtask

  task automatic mid_reset();
    #2 rst_in = 1'b1;
    #1 check_all_zero("_mid");
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) hist[i].valid = 1'b0;
    chk_en      = 1'b0;
    prev_ok     = 1'b0;
    model_front = 1'b0;
    model_ack   = 1'b0;
    pending     = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) hist[i].valid = 1'b0;
    #1 rst_in = 1'b1;
    #2 check_all_zero("_init");
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;

    for (int f = 0; f < 6; f++) begin
      cur_frame  = f;
      frame_acks = 0;
      if (f == 5) chk_en = 1'b1;
      for (int v = 0; v < 525; v++) begin
        for (int i = 0; i < 12; i++) begin
          bit req;
          req = 1'b0;
          if (f == 1 && v == 100 && HS[i] == 0) req = 1'b1;
          if (f == 2 && HS[i] == 0 && (v == 50 || v == 150 || v == 490)) req = 1'b1;
          step(HS[i], v, req);
          if (f == 4 && v == 200 && HS[i] == 300) mid_reset();
          if (f == 4 && v == 200 && HS[i] == 319) mid_reset();
        end
      end
      case (f)
        0: begin
          check("max_addr", 32'(max_addr), 76799);
          check("acks_f0", 32'(frame_acks), 0);
        end
        1: begin
          check("acks_f1", 32'(frame_acks), 1);
          check("front_f1", 32'(front_sel_out), 1);
        end
        2: begin
          check("acks_f2", 32'(frame_acks), 1);
          check("front_f2", 32'(front_sel_out), 0);
        end
        3: begin
          check("acks_f3", 32'(frame_acks), 0);
          check("front_f3", 32'(front_sel_out), 0);
        end
        5: check("acks_f5", 32'(frame_acks), 0);
        default: ;
      endcase
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
